latex_uart_tx: RTL and testbench
================================

# latex_uart_tx

Serial output stage for the Laplace-transform LaTeX generator: it sits directly downstream of the transformer and takes the ASCII bytes it produces. It buffers them in a small FIFO and transmits them as 8N1 UART frames on one pin. It also appends CR LF after the last character of each transform, so a terminal shows one transform per line.

## Interface
- `CLKS_PER_BIT`, default 8: clock cycles per UART bit; legal values are ≥ 2.
- `FIFO_DEPTH`, default 4: number of FIFO entries; must be a power of 2 and ≥ 2.
- `clk` input, 1 bit: the single clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_data` input, 8 bits: ASCII character from the transformer (lhs or rhs byte).
- `in_last` input, 1 bit: marks `in_data` as the final character of a transform; CR LF follows it on the wire.
- `in_valid` input, 1 bit: `in_data`/`in_last` are valid this cycle.
- `in_ready` output, 1 bit: the FIFO can accept an entry this cycle.
- `tx` output, 1 bit: UART serial line; idles high.
- `busy` output, 1 bit: the FSM is not in IDLE, or the FIFO is non-empty.
- `fifo_count` output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

## Operation
- **Push:** on a rising edge with `in_valid && in_ready`, write {`in_last`, `in_data`} (9 bits) into the FIFO.
- **Ready:** `in_ready = (fifo_count != FIFO_DEPTH)`. It is derived from the registered count and is combinational to the output. A pop in the same cycle does not free a slot for a push; there is no full-pass-through.
- **FSM states:** IDLE, START, DATA, STOP.
- **Shifter and tag:** an 8-bit shift register, a 3-bit bit index, and a baud counter of width $clog2(CLKS_PER_BIT). A 2-bit `pend` tag holds NONE, CR or LF.
- **IDLE:** `tx`=1.
  - If `pend`≠NONE, load 0x0D (CR) or 0x0A (LF) accordingly. Otherwise, if the FIFO is non-empty, pop its head and load it.
  - Either load moves to START.
- **START:** `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- **DATA:** `tx`=shift[0], LSB first, each bit held CLKS_PER_BIT cycles. Shift right after each bit; after bit 7 go to STOP.
- **STOP:** `tx`=1 for CLKS_PER_BIT cycles. On its final cycle, apply the IDLE load decision directly.
  - If a byte is available, go straight to START; no extra idle cycle.
  - Otherwise go to IDLE.
- **`pend` update:**
  - Popping an entry with `last`=1 sets `pend`=CR.
  - Loading CR sets `pend`=LF.
  - Loading LF sets `pend`=NONE.
  - CR/LF take priority over the FIFO, so a popped `last` character is always followed immediately by CR then LF.
- **No data loss:** once accepted, every byte is transmitted; there is no overflow path.

## Timing
- **Reset values:** `tx`=1, `in_ready`=1, `busy`=0, `fifo_count`=0. State is IDLE and `pend`=NONE; FIFO pointers are 0.
- **Reset mid-frame:** `tx` goes high asynchronously. The partial frame and all FIFO contents are discarded.
- **Latency:** with the FIFO empty and the FSM in IDLE, a push at edge E0 gives `fifo_count`=1 after E0. IDLE pops at E1, and `tx` falls after E1, i.e. 1 cycle from accept to start bit.
- **Frame length:** 10·CLKS_PER_BIT cycles.
- **Back-to-back bytes:** no gap between the end of one stop bit and the next start bit.
- **`in_last` character:** produces 3 consecutive frames (char, CR, LF), 30·CLKS_PER_BIT cycles in total.
- **Simultaneous push and pop at non-full:** `fifo_count` is unchanged. At empty, the push proceeds and the pop does not occur that cycle.
- **Baud counter:** wraps to 0 at CLKS_PER_BIT-1. The bit index wraps after 7.

## Structure
- **Package `latex_uart_pkg`:**
  - state enum (IDLE/START/DATA/STOP);
  - `pend` enum (NONE/CR/LF);
  - constants `ASCII_CR`=8'h0D, `ASCII_LF`=8'h0A, `FRAME_BITS`=10.
- **Sub-module `char_fifo`:** synchronous FIFO, 9-bit entries, parameter FIFO_DEPTH. Ports push/pop/din/dout/count. Same `clk`/`rst_n`.
- **Top of this block:** FSM, shifter, baud counter, `pend` logic.

## Test plan
- **Single byte:** CLKS_PER_BIT=4; push 0x41 (`in_last`=0) into an idle block → `tx` falls 1 cycle after accept. Line reads 0, 1,0,0,0,0,0,1,0, 1, each bit 4 cycles. `busy` deasserts after 40 cycles.
- **CR LF insertion:** push 0x5C with `in_last`=1 → frames 0x5C, 0x0D, 0x0A back-to-back (120 cycles at CLKS_PER_BIT=4); `busy` low afterwards.
- **Backpressure:** FIFO_DEPTH=4; hold `in_valid` with bytes 0x30..0x36 → `in_ready` drops once the FIFO is full. All 7 bytes appear on `tx` in order, none duplicated or lost.
- **Priority:** queue 'a'(`last`=1) then 'b' → wire order a, CR, LF, b with no idle gap.
- **Reset mid-frame:** assert `rst_n`=0 during DATA bit 3 → `tx`=1 immediately, `fifo_count`=0. After release, a new push of 0x55 transmits cleanly.
- **Minimum baud:** CLKS_PER_BIT=2, three queued bytes → each frame is exactly 20 cycles; stop-to-start transitions are contiguous.

Source files
------------

// File: rtl/latex_uart_pkg.sv
// Shared types and constants for the LaTeX transform UART output stage.
// Holds the transmit FSM states, the CR/LF pending tag and the FIFO entry layout.
package latex_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_CR   = 2'd1,
    PEND_LF   = 2'd2
  } pend_e;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam int         FRAME_BITS = 10;

  // One queued character plus its end-of-transform marker.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  function automatic logic [7:0] pend_char(input pend_e p);
    return (p == PEND_CR) ? ASCII_CR : ASCII_LF;
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Synchronous FIFO of 9-bit {last, data} entries between the transformer and the UART.
// Pointers wrap naturally because the depth is a power of two.
module char_fifo
  import latex_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  fifo_entry_t                   din_i,
  output fifo_entry_t                   dout_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  fifo_entry_t      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Callers only push when not full and pop when non-empty; the guards keep
  // the pointers consistent even if that contract is broken.
  assign do_push = push_i && (count_q != FULL_COUNT);
  assign do_pop  = pop_i  && (count_q != '0);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/latex_uart_tx.sv
// 8N1 UART transmitter for the Laplace-transform LaTeX generator output.
// Buffers characters in a FIFO and appends CR LF after each end-of-transform character.
module latex_uart_tx
  import latex_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  in_data,
  input  logic                        in_last,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);

  tx_state_e         state_q;
  pend_e             pend_q;
  logic [7:0]        shift_q;
  logic [2:0]        bit_idx_q;
  logic [BAUD_W-1:0] baud_q;
  logic              tx_q;

  fifo_entry_t       fifo_din;
  fifo_entry_t       fifo_dout;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_push;
  logic              fifo_pop;

  logic              baud_done;
  logic              decide_now;
  logic              load_ok;
  logic              load_from_fifo;
  logic [7:0]        load_byte;
  pend_e             load_pend;

  // Handshake: a character is accepted on any rising edge where in_valid and
  // in_ready are both high. in_ready depends only on the registered count, so a
  // pop in the same cycle never frees a slot for a push.
  assign in_ready  = (fifo_cnt != FULL_COUNT);
  assign fifo_push = in_valid && in_ready;
  assign fifo_din  = '{last: in_last, data: in_data};

  char_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .count_o (fifo_cnt)
  );

  assign baud_done  = (baud_q == BAUD_LAST);
  assign decide_now = (state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_done);

  // Next-character selection: a pending CR/LF always wins over the FIFO so the
  // line terminator follows its end-of-transform character immediately.
  always_comb begin
    load_ok        = 1'b0;
    load_from_fifo = 1'b0;
    load_byte      = 8'h00;
    load_pend      = pend_q;
    if (pend_q != PEND_NONE) begin
      load_ok   = 1'b1;
      load_byte = pend_char(pend_q);
      load_pend = (pend_q == PEND_CR) ? PEND_LF : PEND_NONE;
    end else if (fifo_cnt != '0) begin
      load_ok        = 1'b1;
      load_from_fifo = 1'b1;
      load_byte      = fifo_dout.data;
      load_pend      = fifo_dout.last ? PEND_CR : PEND_NONE;
    end
  end

  assign fifo_pop = decide_now && load_from_fifo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pend_q    <= PEND_NONE;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      baud_q    <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (load_ok) begin
            state_q <= ST_START;
            shift_q <= load_byte;
            pend_q  <= load_pend;
            baud_q  <= '0;
            tx_q    <= 1'b0;
          end
        end

        ST_START: begin
          if (baud_done) begin
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            state_q   <= ST_DATA;
            tx_q      <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (baud_done) begin
            baud_q    <= '0;
            bit_idx_q <= bit_idx_q + 3'd1;
            shift_q   <= {1'b0, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        ST_STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            // Chain straight into the next start bit when anything is waiting.
            if (load_ok) begin
              state_q <= ST_START;
              shift_q <= load_byte;
              pend_q  <= load_pend;
              tx_q    <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != ST_IDLE) || (fifo_cnt != '0);
  assign fifo_count = fifo_cnt;

endmodule

// File: tb/tb_latex_uart_tx.sv
// Self-checking bench for latex_uart_tx: line waveforms are compared cycle by
// cycle against an ideal 8N1 waveform built from the expected character stream.
module tb_latex_uart_tx;

  localparam int C_A   = 4;
  localparam int C_B   = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_valid_a = 1'b0;
  logic       in_valid_b = 1'b0;

  logic       in_ready_a, tx_a, busy_a;
  logic [2:0] fifo_count_a;
  logic       in_ready_b, tx_b, busy_b;
  logic [2:0] fifo_count_b;

  latex_uart_tx #(.CLKS_PER_BIT(C_A), .FIFO_DEPTH(DEPTH)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .tx(tx_a), .busy(busy_a),
    .fifo_count(fifo_count_a)
  );

  latex_uart_tx #(.CLKS_PER_BIT(C_B), .FIFO_DEPTH(DEPTH)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .tx(tx_b), .busy(busy_b),
    .fifo_count(fifo_count_b)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       obs_q[$];
  int         fall_cyc;
  int         accept_cyc;

  // Ideal line level t cycles after the first start bit, for the frames in exp_q.
  function automatic logic model_bit(input int t, input int c);
    int f;
    int b;
    logic [7:0] ch;
    f = t / (10 * c);
    b = (t % (10 * c)) / c;
    if (f >= exp_q.size()) return 1'b1;
    ch = exp_q[f];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return ch[b-1];
  endfunction

  // Driver: called at a falling edge; returns at the falling edge after acceptance.
  task automatic push_byte(input int sel, input logic [7:0] d, input logic l);
    int waited;
    waited = 0;
    in_data = d;
    in_last = l;
    if (sel == 0) in_valid_a = 1'b1; else in_valid_b = 1'b1;
    while ((((sel == 0) ? in_ready_a : in_ready_b) !== 1'b1) && (waited < 500)) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 500) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready stayed low, got %0d cycles, required < 500", waited);
    end
    @(negedge clk);
    accept_cyc = cyc;
    if (sel == 0) in_valid_a = 1'b0; else in_valid_b = 1'b0;
    exp_q.push_back(d);
    if (l) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  // Line capture: waits for a start bit then records n per-cycle samples.
  task automatic capture(input int sel, input int n, output bit timed_out);
    int w;
    w = 0;
    timed_out = 1'b0;
    obs_q.delete();
    @(negedge clk);
    while ((((sel == 0) ? tx_a : tx_b) !== 1'b0) && (w < 400)) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) begin
      timed_out = 1'b1;
    end else begin
      fall_cyc = cyc;
      obs_q.push_back((sel == 0) ? tx_a : tx_b);
      for (int i = 1; i < n; i++) begin
        @(negedge clk);
        obs_q.push_back((sel == 0) ? tx_a : tx_b);
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", tx_a); end
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy_a); end
    checks++; if (fifo_count_a !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", fifo_count_a); end
    checks++; if (tx_b !== 1'b1) begin errors++; $display("FAIL reset_tx_b: got %b, required 1", tx_b); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte();
    bit to;
    exp_q.delete();
    fork
      push_byte(0, 8'h41, 1'b0);
      capture(0, 10 * C_A, to);
    join
    checks++;
    if (to) begin
      errors++; $display("FAIL single_start: no start bit seen, got timeout, required fall");
    end else begin
      checks++;
      if (fall_cyc - accept_cyc != 1) begin
        errors++; $display("FAIL single_latency: got %0d, required 1", fall_cyc - accept_cyc);
      end
      for (int t = 0; t < 10 * C_A; t++) begin
        checks++;
        if (obs_q[t] !== model_bit(t, C_A)) begin
          errors++; $display("FAIL single_wave t=%0d: got %b, required %b", t, obs_q[t], model_bit(t, C_A));
        end
      end
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy_last: got %b, required 1", busy_a); end
      @(negedge clk);
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b, required 0", busy_a); end
    end
  endtask

  task automatic test_crlf();
    bit to;
    exp_q.delete();
    fork
      push_byte(0, 8'h5C, 1'b1);
      capture(0, 30 * C_A, to);
    join
    checks++;
    if (to) begin
      errors++; $display("FAIL crlf_start: got timeout, required fall");
    end else begin
      for (int t = 0; t < 30 * C_A; t++) begin
        checks++;
        if (obs_q[t] !== model_bit(t, C_A)) begin
          errors++; $display("FAIL crlf_wave t=%0d: got %b, required %b", t, obs_q[t], model_bit(t, C_A));
        end
      end
      @(negedge clk);
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL crlf_busy_end: got %b, required 0", busy_a); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    bit saw_full;
    saw_full = 1'b0;
    exp_q.delete();
    fork
      for (int i = 0; i < 7; i++) push_byte(0, 8'h30 + 8'(i), 1'b0);
      capture(0, 70 * C_A, to);
      repeat (300) begin
        @(negedge clk);
        if (in_ready_a === 1'b0) begin
          saw_full = 1'b1;
          checks++;
          if (fifo_count_a !== 3'd4) begin
            errors++; $display("FAIL bp_ready_low_count: got %0d, required 4", fifo_count_a);
          end
        end
      end
    join
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL bp_ready_drop: got %b, required 1", saw_full); end
    checks++; if (exp_q.size() != 7) begin errors++; $display("FAIL bp_accepted: got %0d, required 7", exp_q.size()); end
    checks++;
    if (to) begin
      errors++; $display("FAIL bp_start: got timeout, required fall");
    end else begin
      for (int t = 0; t < 70 * C_A; t++) begin
        checks++;
        if (obs_q[t] !== model_bit(t, C_A)) begin
          errors++; $display("FAIL bp_wave t=%0d: got %b, required %b", t, obs_q[t], model_bit(t, C_A));
        end
      end
    end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL bp_busy_end: got %b, required 0", busy_a); end
  endtask

  task automatic test_priority();
    bit to;
    exp_q.delete();
    fork
      begin
        push_byte(0, 8'h61, 1'b1);
        push_byte(0, 8'h62, 1'b0);
      end
      capture(0, 40 * C_A, to);
    join
    checks++;
    if (to) begin
      errors++; $display("FAIL prio_start: got timeout, required fall");
    end else begin
      for (int t = 0; t < 40 * C_A; t++) begin
        checks++;
        if (obs_q[t] !== model_bit(t, C_A)) begin
          errors++; $display("FAIL prio_wave t=%0d: got %b, required %b", t, obs_q[t], model_bit(t, C_A));
        end
      end
      @(negedge clk);
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL prio_busy_end: got %b, required 0", busy_a); end
    end
  endtask

  task automatic test_random();
    bit to;
    int n;
    int frames;
    logic [7:0] d [6];
    logic       l [6];
    for (int r = 0; r < 3; r++) begin
      exp_q.delete();
      n = $urandom_range(2, 6);
      frames = 0;
      for (int i = 0; i < n; i++) begin
        d[i] = 8'($urandom_range(0, 255));
        l[i] = ($urandom_range(0, 3) == 0);
        frames += l[i] ? 3 : 1;
      end
      fork
        for (int i = 0; i < n; i++) push_byte(0, d[i], l[i]);
        capture(0, frames * 10 * C_A, to);
      join
      checks++;
      if (to) begin
        errors++; $display("FAIL rand_start round %0d: got timeout, required fall", r);
      end else begin
        for (int t = 0; t < frames * 10 * C_A; t++) begin
          checks++;
          if (obs_q[t] !== model_bit(t, C_A)) begin
            errors++; $display("FAIL rand_wave r=%0d t=%0d: got %b, required %b", r, t, obs_q[t], model_bit(t, C_A));
          end
        end
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rand_busy_end r=%0d: got %b, required 0", r, busy_a); end
      end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    exp_q.delete();
    fork
      begin
        push_byte(0, 8'h41, 1'b0);
        push_byte(0, 8'h42, 1'b0);
        push_byte(0, 8'h43, 1'b0);
      end
      capture(0, 4 * C_A + 2, to);
    join
    checks++;
    if (to) begin
      errors++; $display("FAIL rst_mid_start: got timeout, required fall");
    end else begin
      checks++; if (tx_a !== 1'b0) begin errors++; $display("FAIL rst_mid_bit3: got %b, required 0", tx_a); end
      checks++; if (fifo_count_a !== 3'd2) begin errors++; $display("FAIL rst_mid_count_before: got %0d, required 2", fifo_count_a); end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL rst_mid_tx: got %b, required 1", tx_a); end
    checks++; if (fifo_count_a !== 3'd0) begin errors++; $display("FAIL rst_mid_count: got %0d, required 0", fifo_count_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b, required 0", busy_a); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    fork
      push_byte(0, 8'h55, 1'b0);
      capture(0, 10 * C_A, to);
    join
    checks++;
    if (to) begin
      errors++; $display("FAIL rst_after_start: got timeout, required fall");
    end else begin
      checks++;
      if (fall_cyc - accept_cyc != 1) begin
        errors++; $display("FAIL rst_after_latency: got %0d, required 1", fall_cyc - accept_cyc);
      end
      for (int t = 0; t < 10 * C_A; t++) begin
        checks++;
        if (obs_q[t] !== model_bit(t, C_A)) begin
          errors++; $display("FAIL rst_after_wave t=%0d: got %b, required %b", t, obs_q[t], model_bit(t, C_A));
        end
      end
      @(negedge clk);
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_after_busy: got %b, required 0", busy_a); end
    end
  endtask

  task automatic test_min_baud();
    bit to;
    exp_q.delete();
    fork
      for (int i = 0; i < 3; i++) push_byte(1, 8'($urandom_range(0, 255)), 1'b0);
      capture(1, 30 * C_B, to);
    join
    checks++;
    if (to) begin
      errors++; $display("FAIL minbaud_start: got timeout, required fall");
    end else begin
      for (int t = 0; t < 30 * C_B; t++) begin
        checks++;
        if (obs_q[t] !== model_bit(t, C_B)) begin
          errors++; $display("FAIL minbaud_wave t=%0d: got %b, required %b", t, obs_q[t], model_bit(t, C_B));
        end
      end
      @(negedge clk);
      checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL minbaud_busy_end: got %b, required 0", busy_b); end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    repeat (3) @(negedge clk);
    test_crlf();
    repeat (3) @(negedge clk);
    test_backpressure();
    repeat (3) @(negedge clk);
    test_priority();
    repeat (3) @(negedge clk);
    test_random();
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    test_min_baud();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
